pll_supervisor: RTL and testbench

PLL_SUPERVISOR -- requirements
Module: pll_supervisor

---
 rtl/pll_supervisor.sv | 154 +++++++++++++++
 tb/tb_pll_supervisor.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_supervisor.sv
// PLL lock supervisor: pulses the rPLL reset, waits for a stable lock,
// releases the system reset once lock is trusted, and retries or faults
// when lock never arrives.
module pll_supervisor #(
   parameter int RST_CYCLES   = 27,
   parameter int LOCK_TIMEOUT = 27000,
   parameter int LOCK_STABLE  = 256,
   parameter int MAX_RETRY    = 3
) (
   input  logic       clkin,
   input  logic       rst_n,
   input  logic       pll_lock,
   input  logic       relock_req,
   output logic       pll_reset,
   output logic       sys_rst_n,
   output logic       locked,
   output logic       fault,
   output logic [3:0] retry_cnt,
   output logic [7:0] lost_cnt
);

   typedef enum logic [2:0] {
      S_RESET_PLL,
      S_WAIT_LOCK,
      S_STABLE,
      S_RUN,
      S_FAULT
   } state_t;

   // The timer must hold the largest terminal count of any timed state.
   localparam int TMAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int TMAX   = (TMAX_A > LOCK_STABLE) ? TMAX_A : LOCK_STABLE;
   localparam int TW     = $clog2(TMAX + 1);

   // The WAIT_LOCK exit cycle already counts as the first stable sample,
   // so STABLE needs LOCK_STABLE-1 more cycles (timer 0..LOCK_STABLE-2).
   localparam int STB_LAST_I = (LOCK_STABLE >= 2) ? LOCK_STABLE - 2 : 0;

   localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] STB_LAST = TW'(STB_LAST_I);
   localparam logic [3:0]    MAX_R    = 4'(MAX_RETRY);

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [3:0]      retry_q, retry_d;
   logic [7:0]      lost_q, lost_d;
   logic            lock_meta_q, lock_meta_d;
   logic            lock_s_q, lock_s_d;
   logic            pll_reset_q, pll_reset_d;
   logic            sys_rst_n_q, sys_rst_n_d;
   logic            locked_q, locked_d;
   logic            fault_q, fault_d;

   // Two-flop synchronizer inputs for the asynchronous lock signal.
   always_comb begin
      lock_meta_d = pll_lock;
      lock_s_d    = lock_meta_q;
   end

   // Next state, shared timer and the retry / loss counters.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      retry_d = retry_q;
      lost_d  = lost_q;
      if (relock_req) begin
         state_d = S_RESET_PLL;
         retry_d = 4'd0;
      end else begin
         case (state_q)
            S_RESET_PLL: begin
               if (timer_q == RST_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
               // Lock wins over a coincident timeout.
               if (lock_s_q) begin
                  state_d = S_STABLE;
               end else if (timer_q == TO_LAST) begin
                  retry_d = retry_q + 4'd1;
                  state_d = (retry_d == MAX_R) ? S_FAULT : S_RESET_PLL;
               end
            end
            S_STABLE: begin
               if (!lock_s_q) begin
                  state_d = S_WAIT_LOCK;
               end else if (timer_q >= STB_LAST) begin
                  state_d = S_RUN;
                  retry_d = 4'd0;
               end
            end
            S_RUN: begin
               if (!lock_s_q) begin
                  state_d = S_RESET_PLL;
                  if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
               end
            end
            S_FAULT: begin
               state_d = S_FAULT;
            end
            default: state_d = S_RESET_PLL;
         endcase
      end
      // Fresh timer on every state entry and on a relock (restarts the pulse).
      if (relock_req || (state_d != state_q)) begin
         timer_d = '0;
      end else if (state_q inside {S_RESET_PLL, S_WAIT_LOCK, S_STABLE}) begin
         timer_d = timer_q + TW'(1);
      end
   end

   // Registered output decode of the current state.
   always_comb begin
      pll_reset_d = (state_q == S_RESET_PLL) || (state_q == S_FAULT);
      sys_rst_n_d = (state_q == S_RUN);
      locked_d    = (state_q == S_RUN);
      fault_d     = (state_q == S_FAULT);
   end

   // State, synchronizer and output registers with synchronous reset.
   always_ff @(posedge clkin) begin
      if (!rst_n) begin
         state_q     <= S_RESET_PLL;
         timer_q     <= '0;
         retry_q     <= 4'd0;
         lost_q      <= 8'd0;
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
         pll_reset_q <= 1'b1;
         sys_rst_n_q <= 1'b0;
         locked_q    <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         retry_q     <= retry_d;
         lost_q      <= lost_d;
         lock_meta_q <= lock_meta_d;
         lock_s_q    <= lock_s_d;
         pll_reset_q <= pll_reset_d;
         sys_rst_n_q <= sys_rst_n_d;
         locked_q    <= locked_d;
         fault_q     <= fault_d;
      end
   end

   assign pll_reset = pll_reset_q;
   assign sys_rst_n = sys_rst_n_q;
   assign locked    = locked_q;
   assign fault     = fault_q;
   assign retry_cnt = retry_q;
   assign lost_cnt  = lost_q;

endmodule

// File: tb/tb_pll_supervisor.sv
// Bench for pll_supervisor: directed scenarios plus random lock/relock/reset
// traffic, every cycle compared against a phase-level reference model.
module tb_pll_supervisor;

   localparam int RST = 4;
   localparam int TO  = 20;
   localparam int STB = 8;
   localparam int MR  = 2;

   logic       clkin = 1'b0;
   logic       rst_n = 1'b0;
   logic       pll_lock = 1'b0;
   logic       relock_req = 1'b0;
   logic       pll_reset, sys_rst_n, locked, fault;
   logic [3:0] retry_cnt;
   logic [7:0] lost_cnt;

   int checks = 0;
   int errors = 0;

   pll_supervisor #(
      .RST_CYCLES(RST), .LOCK_TIMEOUT(TO), .LOCK_STABLE(STB), .MAX_RETRY(MR)
   ) dut (
      .clkin(clkin), .rst_n(rst_n), .pll_lock(pll_lock), .relock_req(relock_req),
      .pll_reset(pll_reset), .sys_rst_n(sys_rst_n), .locked(locked), .fault(fault),
      .retry_cnt(retry_cnt), .lost_cnt(lost_cnt)
   );

   always #5 clkin = ~clkin;

   // Reference model: phase plus cycles-left / lock-streak bookkeeping.
   localparam int P_PULSE = 0, P_WAIT = 1, P_STABLE = 2, P_RUN = 3, P_FAULT = 4;
   int ph = P_PULSE, left = RST, streak = 0, m_retry = 0, m_lost = 0;
   bit s1 = 0, s2 = 0;
   bit m_pll_reset = 1, m_sys_rst_n = 0, m_locked = 0, m_fault = 0;

   always @(posedge clkin) begin
      bit ls;
      if (!rst_n) begin
         ph = P_PULSE; left = RST; streak = 0; m_retry = 0; m_lost = 0;
         s1 = 0; s2 = 0;
         m_pll_reset = 1; m_sys_rst_n = 0; m_locked = 0; m_fault = 0;
      end else begin
         // outputs show the phase held during the cycle just ended
         m_pll_reset = (ph == P_PULSE) || (ph == P_FAULT);
         m_sys_rst_n = (ph == P_RUN);
         m_locked    = (ph == P_RUN);
         m_fault     = (ph == P_FAULT);
         ls = s2; s2 = s1; s1 = pll_lock;
         if (relock_req) begin
            ph = P_PULSE; left = RST; m_retry = 0;
         end else begin
            case (ph)
               P_PULSE: begin
                  left--;
                  if (left == 0) begin ph = P_WAIT; left = TO; end
               end
               P_WAIT: begin
                  if (ls) begin
                     ph = P_STABLE; streak = 1;
                  end else begin
                     left--;
                     if (left == 0) begin
                        m_retry++;
                        if (m_retry == MR) ph = P_FAULT;
                        else begin ph = P_PULSE; left = RST; end
                     end
                  end
               end
               P_STABLE: begin
                  if (!ls) begin
                     ph = P_WAIT; left = TO;
                  end else begin
                     streak++;
                     if (streak >= STB) begin ph = P_RUN; m_retry = 0; end
                  end
               end
               P_RUN: begin
                  if (!ls) begin
                     if (m_lost < 255) m_lost++;
                     ph = P_PULSE; left = RST;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock: let the edge happen, then compare all outputs mid-cycle.
   task automatic cyc();
      @(posedge clkin);
      @(negedge clkin);
      chk("pll_reset", pll_reset, m_pll_reset);
      chk("sys_rst_n", sys_rst_n, m_sys_rst_n);
      chk("locked",    locked,    m_locked);
      chk("fault",     fault,     m_fault);
      chk("retry_cnt", retry_cnt, m_retry);
      chk("lost_cnt",  lost_cnt,  m_lost);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int hold;

      // Reset state and pulse width after release.
      rst_n = 0; pll_lock = 0; relock_req = 0;
      run(3);
      chk("rst_pll_reset", pll_reset, 1);
      chk("rst_sys_rst_n", sys_rst_n, 0);
      chk("rst_lost", lost_cnt, 0);
      rst_n = 1;
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         cyc();
         if (pll_reset) cnt++;
         else break;
      end
      chk("pulse_width", cnt, RST);

      // Lock 3 cycles after pll_reset falls; sys_rst_n after 2+STB cycles.
      run(2);
      pll_lock = 1;
      cnt = -1;
      for (int i = 0; i < 100; i++) begin
         cyc();
         cnt++;
         if (sys_rst_n) break;
      end
      chk("lock_latency", cnt, 2 + STB);
      chk("locked_run", locked, 1);
      chk("retry_run", retry_cnt, 0);

      // No lock at all: two failed attempts, then FAULT; relock recovers.
      rst_n = 0; pll_lock = 0;
      cyc();
      rst_n = 1;
      run(60);
      chk("fault_set", fault, 1);
      chk("fault_retry", retry_cnt, MR);
      chk("fault_pll_reset", pll_reset, 1);
      relock_req = 1;
      cyc();
      relock_req = 0;
      cyc();
      chk("relock_fault", fault, 0);
      chk("relock_retry", retry_cnt, 0);
      chk("relock_pulse", pll_reset, 1);

      // Reach RUN, drop lock for one cycle, then many losses to saturate.
      pll_lock = 1;
      run(30);
      chk("run_again", locked, 1);
      pll_lock = 0;
      cyc();
      pll_lock = 1;
      run(4);
      chk("lost_one", lost_cnt, 1);
      run(20);
      for (int k = 0; k < 299; k++) begin
         pll_lock = 0;
         cyc();
         pll_lock = 1;
         run(19);
      end
      chk("lost_sat", lost_cnt, 255);
      chk("locked_after_sat", locked, 1);

      // Glitch during STABLE restarts the wait; a clean run then locks.
      relock_req = 1;
      cyc();
      relock_req = 0;
      run(6);
      pll_lock = 0;
      cyc();
      pll_lock = 1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         chk("glitch_no_run", locked, 0);
      end
      run(10);
      chk("glitch_then_run", locked, 1);

      // Reset in RUN together with relock_req, then reset mid-pulse.
      rst_n = 0; relock_req = 1;
      cyc();
      chk("rstrun_pll_reset", pll_reset, 1);
      chk("rstrun_sys_rst_n", sys_rst_n, 0);
      chk("rstrun_locked", locked, 0);
      chk("rstrun_lost", lost_cnt, 0);
      rst_n = 1; relock_req = 0;
      run(2);
      rst_n = 0;
      cyc();
      rst_n = 1;
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         cyc();
         if (pll_reset) cnt++;
         else break;
      end
      chk("midpulse_width", cnt, RST);

      // Random lock runs with occasional relock and reset.
      hold = 0;
      for (int i = 0; i < 4000; i++) begin
         if (hold == 0) begin
            pll_lock = ~pll_lock;
            hold = (pll_lock) ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 30));
         end
         hold--;
         relock_req = ($urandom_range(0, 99) == 0);
         rst_n      = ($urandom_range(0, 299) != 0);
         cyc();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
